control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_RESET_HOLD, default 1, meaning the number of cycles reset_pc is held high after reset release (legal range 1..15).
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, a synchronous, active-low reset sampled on the CLK rising edge.
REQ-004 SHALL have port instr, input, 32, the instruction word from instruction memory at the current PC.
REQ-005 SHALL have port instr_valid, input, 1, high when instr is valid for the current PC.
REQ-006 SHALL have ports rs1, rs2, rd, output, 5 each, register addresses taken from the latched instruction (IR[19:15], IR[24:20], IR[11:7]).
REQ-007 SHALL have port immediate, output, 12, the sign-carrying immediate field for the datapath.
REQ-008 SHALL have ports sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc, reset_pc, output, 1 each, the datapath control signals.
REQ-009 SHALL have port illegal, output, 1, sticky flag for an undecodable instruction.
REQ-010 SHALL have port retired, output, 16, the count of completed instructions.

Function
REQ-011 SHALL implement a Moore FSM with states INIT, FETCH, DECODE, EXECUTE, MEM, HALT; outputs depend only on state and the internal 32-bit IR.
REQ-012 INIT SHALL assert reset_pc=1 for PC_RESET_HOLD cycles, counted by an internal counter, then go to FETCH.
REQ-013 FETCH SHALL stay in FETCH while instr_valid=0; when instr_valid=1, IR SHALL latch instr at that edge and the state SHALL go to DECODE.
REQ-014 DECODE SHALL classify IR: ld (opcode 0000011, funct3 011), sd (0100011, 011), add (0110011, 000, funct7 0000000), sub (0110011, 000, funct7 0100000), addi (0010011, 000); any other encoding SHALL go to HALT, otherwise to EXECUTE.
REQ-015 immediate SHALL be IR[31:20] for ld/addi, {IR[31:25],IR[11:7]} for sd, and 0 for add/sub and all non-decoded states.
REQ-016 EXECUTE for add/sub SHALL drive ULA_din2_sel=0, RF_din_sel=1, WE_RF=1, load_pc=1, with sub=1 only for sub; next state FETCH.
REQ-017 EXECUTE for addi SHALL drive ULA_din2_sel=1, RF_din_sel=1, WE_RF=1, sub=0, load_pc=1; next state FETCH.
REQ-018 EXECUTE for sd SHALL drive ULA_din2_sel=1, sub=0, WE_MEM=1, WE_RF=0, load_pc=1; next state FETCH.
REQ-019 EXECUTE for ld SHALL drive ULA_din2_sel=1, sub=0, with WE_RF=0 and WE_MEM=0; next state MEM.
REQ-020 MEM SHALL drive ULA_din2_sel=1, RF_din_sel=0, WE_RF=1, load_pc=1; next state FETCH.
REQ-021 Latency from FETCH acceptance SHALL be 3 cycles for add/sub/addi/sd and 4 cycles for ld.
REQ-022 Within one instruction, load_pc SHALL be high for exactly one cycle, and WE_RF and WE_MEM SHALL never both be high.
REQ-023 retired SHALL increment by 1 in each cycle in which load_pc=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 HALT SHALL set illegal=1 and drive all write enables and load_pc to 0; the FSM SHALL stay in HALT until reset.
REQ-025 Signals not listed for a state SHALL be 0; rs1, rs2 and rd SHALL always reflect the IR.

Reset
REQ-026 With reset_n=0 at a rising edge, the FSM SHALL enter INIT, and IR, retired, illegal and the hold counter SHALL clear to 0.
REQ-027 During reset, all 1-bit outputs except reset_pc SHALL be 0, and reset_pc SHALL be 1.
REQ-028 Reset asserted in any state, including mid-instruction in EXECUTE or MEM, SHALL abort the instruction with no write enable asserted in the following cycle.

Verification
REQ-029 Release reset with PC_RESET_HOLD=3 -> reset_pc high for exactly 3 cycles, then state FETCH, retired=0.
REQ-030 Present instr=0x01003083 (ld x1,16(x0)) with instr_valid=1 -> rs1=0, rd=1, immediate=16; MEM cycle shows WE_RF=1, RF_din_sel=0, load_pc=1; retired=1 after 4 cycles.
REQ-031 Present sub x20,x5,x1 (0x40128A33) -> EXECUTE shows sub=1, ULA_din2_sel=0, RF_din_sel=1, WE_RF=1, rd=20, rs1=5, rs2=1.
REQ-032 Present sd x10,10(x0) (0x00A03523) -> immediate=10, WE_MEM=1, WE_RF=0 for one cycle; addi x30,x21,-401 (0xE6FA8F13) -> immediate=0xE6F.
REQ-033 Hold instr_valid=0 for 5 cycles in FETCH, then present 0xFFFFFFFF -> FSM waits with no enables, then HALT with illegal=1 held until reset_n=0.
REQ-034 Assert reset_n=0 during the EXECUTE cycle of sd -> WE_MEM=0 at the next edge, retired unchanged at 0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control FSM for a small load/store core: fetches into an internal
// instruction register, decodes ld/sd/add/sub/addi and sequences the datapath.
module control_unit #(
    parameter int unsigned PC_RESET_HOLD = 1
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [11:0] immediate,
    output logic        sub,
    output logic        ULA_din2_sel,
    output logic        RF_din_sel,
    output logic        WE_RF,
    output logic        WE_MEM,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_SD   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_ADDI = 3'd5
    } op_t;

    localparam logic [3:0] HOLD_LAST = 4'(PC_RESET_HOLD - 1);

    state_t       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [3:0]   hold_q, hold_d;
    logic [15:0]  retired_q, retired_d;
    logic         illegal_q, illegal_d;
    op_t          op_s;
    logic [11:0]  imm_s;

    function automatic op_t classify(input logic [31:0] ir);
        op_t res;
        res = OP_NONE;
        case (ir[6:0])
            7'b0000011: res = (ir[14:12] == 3'b011) ? OP_LD : OP_NONE;
            7'b0100011: res = (ir[14:12] == 3'b011) ? OP_SD : OP_NONE;
            7'b0010011: res = (ir[14:12] == 3'b000) ? OP_ADDI : OP_NONE;
            7'b0110011: begin
                if (ir[14:12] != 3'b000) begin
                    res = OP_NONE;
                end else if (ir[31:25] == 7'b0000000) begin
                    res = OP_ADD;
                end else if (ir[31:25] == 7'b0100000) begin
                    res = OP_SUB;
                end else begin
                    res = OP_NONE;
                end
            end
            default: res = OP_NONE;
        endcase
        return res;
    endfunction

    assign op_s    = classify(ir_q);
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign rd      = ir_q[11:7];
    assign illegal = illegal_q;
    assign retired = retired_q;

    // Immediate field selection by instruction class
    always_comb begin
        imm_s = 12'd0;
        case (op_s)
            OP_LD, OP_ADDI: imm_s = ir_q[31:20];
            OP_SD:          imm_s = {ir_q[31:25], ir_q[11:7]};
            default:        imm_s = 12'd0;
        endcase
    end

    // State and datapath-visible registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q   <= S_INIT;
            ir_q      <= 32'd0;
            hold_q    <= 4'd0;
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            hold_q    <= hold_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        hold_d    = hold_q;
        illegal_d = illegal_q;
        retired_d = load_pc ? (retired_q + 16'd1) : retired_q;
        case (state_q)
            S_INIT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                    hold_d  = 4'd0;
                end else begin
                    hold_d  = hold_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (op_s == OP_NONE) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d   = S_EXECUTE;
                end
            end
            S_EXECUTE: state_d = (op_s == OP_LD) ? S_MEM : S_FETCH;
            S_MEM:     state_d = S_FETCH;
            S_HALT: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
            // Unreachable encodings are treated as a fault and trapped
            default: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Moore outputs decoded from state and instruction register
    always_comb begin
        sub          = 1'b0;
        ULA_din2_sel = 1'b0;
        RF_din_sel   = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = 1'b0;
        immediate    = 12'd0;
        case (state_q)
            S_INIT:   reset_pc  = 1'b1;
            S_DECODE: immediate = imm_s;
            S_EXECUTE: begin
                immediate = imm_s;
                case (op_s)
                    OP_ADD: begin
                        RF_din_sel = 1'b1;
                        WE_RF      = 1'b1;
                        load_pc    = 1'b1;
                    end
                    OP_SUB: begin
                        sub        = 1'b1;
                        RF_din_sel = 1'b1;
                        WE_RF      = 1'b1;
                        load_pc    = 1'b1;
                    end
                    OP_ADDI: begin
                        ULA_din2_sel = 1'b1;
                        RF_din_sel   = 1'b1;
                        WE_RF        = 1'b1;
                        load_pc      = 1'b1;
                    end
                    OP_SD: begin
                        ULA_din2_sel = 1'b1;
                        WE_MEM       = 1'b1;
                        load_pc      = 1'b1;
                    end
                    OP_LD:   ULA_din2_sel = 1'b1;
                    default: ULA_din2_sel = 1'b0;
                endcase
            end
            S_MEM: begin
                immediate    = imm_s;
                ULA_din2_sel = 1'b1;
                WE_RF        = 1'b1;
                load_pc      = 1'b1;
            end
            default: reset_pc = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, randomized legal instructions
// checked against a field-level reference model, plus reset/illegal sequences.
module tb_control_unit;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] immediate;
    logic        sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc, reset_pc, illegal;
    logic [15:0] retired;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_retired = 16'd0;

    control_unit #(.PC_RESET_HOLD(3)) dut (
        .CLK(CLK), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
        .sub(sub), .ULA_din2_sel(ULA_din2_sel), .RF_din_sel(RF_din_sel),
        .WE_RF(WE_RF), .WE_MEM(WE_MEM), .load_pc(load_pc), .reset_pc(reset_pc),
        .illegal(illegal), .retired(retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm;
        logic        sub, din2, rfsel, werf, wemem, is_ld, ill;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc, reset_pc, illegal};
    endfunction

    function automatic logic [7:0] mk(input logic s, input logic d2, input logic rf, input logic wr,
                                      input logic wm, input logic lp, input logic rp, input logic il);
        return {s, d2, rf, wr, wm, lp, rp, il};
    endfunction

    // Reference: classify by field values, then map class to the control it needs
    function automatic exp_t model(input logic [31:0] w);
        exp_t m;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic is_ld, is_sd, is_add, is_sub, is_addi;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        is_ld   = (opc == 7'b0000011) && (f3 == 3'd3);
        is_sd   = (opc == 7'b0100011) && (f3 == 3'd3);
        is_add  = (opc == 7'b0110011) && (f3 == 3'd0) && (f7 == 7'b0000000);
        is_sub  = (opc == 7'b0110011) && (f3 == 3'd0) && (f7 == 7'b0100000);
        is_addi = (opc == 7'b0010011) && (f3 == 3'd0);
        m.word  = w;
        m.rs1   = w[19:15];
        m.rs2   = w[24:20];
        m.rd    = w[11:7];
        m.imm   = (is_ld || is_addi) ? w[31:20] : (is_sd ? {w[31:25], w[11:7]} : 12'd0);
        m.sub   = is_sub;
        m.din2  = is_ld || is_sd || is_addi;
        m.rfsel = is_add || is_sub || is_addi;
        m.werf  = is_add || is_sub || is_addi;
        m.wemem = is_sd;
        m.is_ld = is_ld;
        m.ill   = !(is_ld || is_sd || is_add || is_sub || is_addi);
        return m;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        instr_valid = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", 32'(ctrl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0)));
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_regs", {17'd0, rs1, rs2, rd}, 32'd0);
        reset_n = 1'b1;
        exp_retired = 16'd0;
        for (int i = 0; i < 3; i++) begin
            chk("init_reset_pc", 32'(ctrl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0)));
            tick();
        end
        chk("fetch_after_init", 32'(ctrl_now()), 32'd0);
        chk("fetch_retired", 32'(retired), 32'd0);
    endtask

    // Drive one instruction from FETCH and check every cycle until back in FETCH (or HALT)
    task automatic run_instr(input exp_t e, input int delay, input string tag);
        instr_valid = 1'b0;
        instr = $urandom;
        for (int i = 0; i < delay; i++) begin
            chk({tag, "_wait_ctrl"}, {20'd0, immediate}, 32'd0);
            chk({tag, "_wait_en"}, 32'(ctrl_now()), 32'd0);
            tick();
        end
        instr = e.word;
        instr_valid = 1'b1;
        tick();
        instr = $urandom;
        instr_valid = 1'($urandom_range(0, 1));
        chk({tag, "_dec_ctrl"}, 32'(ctrl_now()), 32'd0);
        chk({tag, "_dec_regs"}, {17'd0, rs1, rs2, rd}, {17'd0, e.rs1, e.rs2, e.rd});
        chk({tag, "_dec_imm"}, {20'd0, immediate}, {20'd0, e.imm});
        tick();
        if (e.ill) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_halt_ctrl"}, 32'(ctrl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 1)));
                chk({tag, "_halt_retired"}, 32'(retired), 32'(exp_retired));
                instr = $urandom;
                instr_valid = 1'b1;
                tick();
            end
        end else begin
            chk({tag, "_ex_ctrl"}, 32'(ctrl_now()),
                32'(mk(e.sub, e.din2, e.rfsel, e.werf, e.wemem, !e.is_ld, 0, 0)));
            chk({tag, "_ex_imm"}, {20'd0, immediate}, {20'd0, e.imm});
            chk({tag, "_ex_regs"}, {17'd0, rs1, rs2, rd}, {17'd0, e.rs1, e.rs2, e.rd});
            if (e.is_ld) begin
                tick();
                chk({tag, "_mem_ctrl"}, 32'(ctrl_now()), 32'(mk(0, 1, 0, 1, 0, 1, 0, 0)));
                chk({tag, "_mem_imm"}, {20'd0, immediate}, {20'd0, e.imm});
            end
            exp_retired = exp_retired + 16'd1;
            tick();
            chk({tag, "_retired"}, 32'(retired), 32'(exp_retired));
            chk({tag, "_back_fetch"}, 32'(ctrl_now()), 32'd0);
        end
    endtask

    exp_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        instr = 32'd0;
        instr_valid = 1'b0;
        reset_n = 1'b0;

        // word, rs1, rs2, rd, imm, sub, din2, rfsel, werf, wemem, is_ld, ill
        vecs[0] = '{32'h01003083, 5'd0, 5'd16, 5'd1,  12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h40128A33, 5'd5, 5'd1,  5'd20, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h00A03523, 5'd0, 5'd10, 5'd10, 12'h00A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hE6FA8F13, 5'd21, 5'd15, 5'd30, 12'hE6F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h005201B3, 5'd4, 5'd5,  5'd3,  12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFF813383, 5'd2, 5'd24, 5'd7,  12'hFF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i], i % 3, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            logic [4:0]  r1, r2, rdd;
            logic [11:0] im;
            int          kind;
            r1 = 5'($urandom); r2 = 5'($urandom); rdd = 5'($urandom); im = 12'($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0:       w = {im, r1, 3'b011, rdd, 7'b0000011};
                1:       w = {im[11:5], r2, r1, 3'b011, im[4:0], 7'b0100011};
                2:       w = {7'b0000000, r2, r1, 3'b000, rdd, 7'b0110011};
                3:       w = {7'b0100000, r2, r1, 3'b000, rdd, 7'b0110011};
                default: w = {im, r1, 3'b000, rdd, 7'b0010011};
            endcase
            run_instr(model(w), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        run_instr(model(32'hFFFFFFFF), 5, "ill_ones");
        do_reset();
        run_instr(model(32'h025201B3), 0, "ill_f7");
        do_reset();
        run_instr(model(32'h01002083), 1, "ill_f3");
        do_reset();

        // Reset during EXECUTE of sd must suppress the memory write
        instr = 32'h00A03523;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("abort_sd_ex", 32'(ctrl_now()), 32'(mk(0, 1, 0, 0, 1, 1, 0, 0)));
        reset_n = 1'b0;
        tick();
        chk("abort_sd_ctrl", 32'(ctrl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0)));
        chk("abort_sd_retired", 32'(retired), 32'd0);
        do_reset();

        // Reset during MEM of ld must suppress the register write
        instr = 32'h01003083;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        chk("abort_ld_mem", 32'(ctrl_now()), 32'(mk(0, 1, 0, 1, 0, 1, 0, 0)));
        reset_n = 1'b0;
        tick();
        chk("abort_ld_ctrl", 32'(ctrl_now()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 0)));
        chk("abort_ld_retired", 32'(retired), 32'd0);
        do_reset();

        run_instr(vecs[4], 0, "post_reset_add");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
